// File: rtl/fifo_buffer_param_if.sv
// Handshake bundle for fifo_buffer_param: control/data in, data/status out.
// master: producer/consumer side. slave: the FIFO itself.
interface fifo_buffer_param_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
);
    logic             flush;
    logic             read_enable;
    logic             write_enable;
    logic             clear_flags;
    logic [WIDTH-1:0] fifo_in;
    logic [WIDTH-1:0] fifo_out;
    logic             data_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic             overflow;
    logic             underflow;
    logic [CNT_W-1:0] fifo_counter;

    modport master (
        output flush, read_enable, write_enable,
        output clear_flags, fifo_in,
        input  fifo_out, data_valid, empty, full,
        input  almost_empty, almost_full,
        input  overflow, underflow, fifo_counter
    );

    modport slave (
        input  flush, read_enable, write_enable,
        input  clear_flags, fifo_in,
        output fifo_out, data_valid, empty, full,
        output almost_empty, almost_full,
        output overflow, underflow, fifo_counter
    );
endinterface

// File: rtl/fifo_buffer_param.sv
// Parametrised single-clock FIFO, registered or show-ahead read.
// Ports: clock, reset (async, active-high), bus (fifo_buffer_param_if.slave).
module fifo_buffer_param #(
    parameter int WIDTH      = 8,
    parameter int DEPTH      = 8,
    parameter int SHOW_AHEAD = 0,
    parameter int AF_LEVEL   = DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input logic                clock,
    input logic                reset,
    fifo_buffer_param_if.slave bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = ($clog2(DEPTH) < 1) ? 1 : $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             full_w;
    logic             empty_w;
    logic             wr_acc;
    logic             rd_acc;
    logic             ovf_set;
    logic             unf_set;
    logic             ovf_q;
    logic             unf_q;

    // Explicit wrap so non-power-of-two depths never alias.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_w  = (count == CNT_W'(DEPTH));
    assign empty_w = (count == '0);

    // flush suppresses both acceptance and error detection.
    assign wr_acc  = bus.write_enable & ~full_w & ~bus.flush;
    assign rd_acc  = bus.read_enable & ~empty_w & ~bus.flush;
    assign ovf_set = bus.write_enable & full_w & ~bus.flush;
    assign unf_set = bus.read_enable & empty_w & ~bus.flush;

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.fifo_in;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_acc) wr_ptr <= ptr_inc(wr_ptr);
            if (rd_acc) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else begin
            unique case (1'b1)
                bus.flush:         count <= '0;
                wr_acc & ~rd_acc:  count <= count + 1'b1;
                rd_acc & ~wr_acc:  count <= count - 1'b1;
                default:           ;
            endcase
        end
    end

    // Set beats a same-cycle clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set)              ovf_q <= 1'b1;
            else if (bus.clear_flags) ovf_q <= 1'b0;
            if (unf_set)              unf_q <= 1'b1;
            else if (bus.clear_flags) unf_q <= 1'b0;
        end
    end

    generate
        if (SHOW_AHEAD == 0) begin : g_reg
            logic [WIDTH-1:0] out_q;
            logic             dv_q;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    out_q <= '0;
                    dv_q  <= 1'b0;
                end else if (bus.flush) begin
                    out_q <= '0;
                    dv_q  <= 1'b0;
                end else begin
                    dv_q <= rd_acc;
                    if (rd_acc) out_q <= mem[rd_ptr];
                end
            end

            assign bus.fifo_out   = out_q;
            assign bus.data_valid = dv_q;
        end else begin : g_fwft
            // Forced to zero while empty so the unreset array
            // never leaks onto the output after reset or flush.
            assign bus.fifo_out   = empty_w ? '0 : mem[rd_ptr];
            assign bus.data_valid = ~empty_w;
        end
    endgenerate

    assign bus.empty        = empty_w;
    assign bus.full         = full_w;
    assign bus.almost_empty = int'(count) <= AE_LEVEL;
    assign bus.almost_full  = int'(count) >= AF_LEVEL;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
    assign bus.fifo_counter = count;
endmodule

// File: tb/tb_fifo_buffer_param.sv
// Self-checking bench: three FIFO configurations on shared stimulus,
// checked each cycle against a queue model plus directed literals.
module tb_fifo_buffer_param;
    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       flush = 1'b0;
    logic       re    = 1'b0;
    logic       we    = 1'b0;
    logic       cf    = 1'b0;
    logic [7:0] din   = 8'h00;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    fifo_buffer_param_if #(.WIDTH(8), .CNT_W(3)) if0 ();
    fifo_buffer_param_if #(.WIDTH(8), .CNT_W(4)) if1 ();
    fifo_buffer_param_if #(.WIDTH(8), .CNT_W(4)) if2 ();

    assign if0.flush = flush;
    assign if0.read_enable = re;
    assign if0.write_enable = we;
    assign if0.clear_flags = cf;
    assign if0.fifo_in = din;
    assign if1.flush = flush;
    assign if1.read_enable = re;
    assign if1.write_enable = we;
    assign if1.clear_flags = cf;
    assign if1.fifo_in = din;
    assign if2.flush = flush;
    assign if2.read_enable = re;
    assign if2.write_enable = we;
    assign if2.clear_flags = cf;
    assign if2.fifo_in = din;

    fifo_buffer_param #(
        .WIDTH(8), .DEPTH(5), .SHOW_AHEAD(0)
    ) u0 (.clock(clock), .reset(reset), .bus(if0.slave));

    fifo_buffer_param #(
        .WIDTH(8), .DEPTH(8), .SHOW_AHEAD(0),
        .AF_LEVEL(6), .AE_LEVEL(2)
    ) u1 (.clock(clock), .reset(reset), .bus(if1.slave));

    fifo_buffer_param #(
        .WIDTH(8), .DEPTH(8), .SHOW_AHEAD(1)
    ) u2 (.clock(clock), .reset(reset), .bus(if2.slave));

    logic [7:0] d_out [3];
    logic [3:0] d_cnt [3];
    logic       d_dv  [3];
    logic       d_em  [3];
    logic       d_fu  [3];
    logic       d_ae  [3];
    logic       d_af  [3];
    logic       d_ov  [3];
    logic       d_un  [3];

    assign d_out[0] = if0.fifo_out;
    assign d_out[1] = if1.fifo_out;
    assign d_out[2] = if2.fifo_out;
    assign d_cnt[0] = {1'b0, if0.fifo_counter};
    assign d_cnt[1] = if1.fifo_counter;
    assign d_cnt[2] = if2.fifo_counter;
    assign d_dv[0] = if0.data_valid;
    assign d_dv[1] = if1.data_valid;
    assign d_dv[2] = if2.data_valid;
    assign d_em[0] = if0.empty;
    assign d_em[1] = if1.empty;
    assign d_em[2] = if2.empty;
    assign d_fu[0] = if0.full;
    assign d_fu[1] = if1.full;
    assign d_fu[2] = if2.full;
    assign d_ae[0] = if0.almost_empty;
    assign d_ae[1] = if1.almost_empty;
    assign d_ae[2] = if2.almost_empty;
    assign d_af[0] = if0.almost_full;
    assign d_af[1] = if1.almost_full;
    assign d_af[2] = if2.almost_full;
    assign d_ov[0] = if0.overflow;
    assign d_ov[1] = if1.overflow;
    assign d_ov[2] = if2.overflow;
    assign d_un[0] = if0.underflow;
    assign d_un[1] = if1.underflow;
    assign d_un[2] = if2.underflow;

    // Model configuration per DUT.
    int m_depth [3] = '{5, 8, 8};
    int m_sa    [3] = '{0, 0, 1};
    int m_af    [3] = '{4, 6, 7};
    int m_ae    [3] = '{1, 2, 1};

    // Model state: contents as a queue, plus registered output.
    logic [7:0] mq  [3][$];
    logic [7:0] mo  [3] = '{default: 8'h00};
    logic       mdv [3] = '{default: 1'b0};
    logic       mov [3] = '{default: 1'b0};
    logic       mun [3] = '{default: 1'b0};

    task automatic model_clear(input int d);
        mq[d].delete();
        mo[d]  = 8'h00;
        mdv[d] = 1'b0;
        mov[d] = 1'b0;
        mun[d] = 1'b0;
    endtask

    always @(posedge reset) begin
        for (int d = 0; d < 3; d++) model_clear(d);
    end

    always @(posedge clock) begin
        for (int d = 0; d < 3; d++) begin
            int  sz;
            bit  is_full;
            bit  is_empty;
            sz       = mq[d].size();
            is_full  = (sz == m_depth[d]);
            is_empty = (sz == 0);
            if (reset) begin
                model_clear(d);
            end else if (flush) begin
                mq[d].delete();
                mo[d]  = 8'h00;
                mdv[d] = 1'b0;
                if (cf) begin
                    mov[d] = 1'b0;
                    mun[d] = 1'b0;
                end
            end else begin
                mdv[d] = 1'b0;
                if (re && !is_empty) begin
                    if (m_sa[d] == 0) begin
                        mo[d]  = mq[d].pop_front();
                        mdv[d] = 1'b1;
                    end else begin
                        void'(mq[d].pop_front());
                    end
                end
                if (we && !is_full) mq[d].push_back(din);
                if (we && is_full) mov[d] = 1'b1;
                else if (cf)       mov[d] = 1'b0;
                if (re && is_empty) mun[d] = 1'b1;
                else if (cf)        mun[d] = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int d,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %0h expected %0h @%0t",
                     nm, d, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clock) begin
        for (int d = 0; d < 3; d++) begin
            int         sz;
            logic [7:0] eo;
            logic       edv;
            sz = mq[d].size();
            if (m_sa[d] != 0) begin
                eo  = (sz != 0) ? mq[d][0] : 8'h00;
                edv = (sz != 0);
            end else begin
                eo  = mo[d];
                edv = mdv[d];
            end
            chk("m_count", d, d_cnt[d], sz);
            chk("m_empty", d, d_em[d], sz == 0);
            chk("m_full", d, d_fu[d], sz == m_depth[d]);
            chk("m_aempty", d, d_ae[d], sz <= m_ae[d]);
            chk("m_afull", d, d_af[d], sz >= m_af[d]);
            chk("m_ovf", d, d_ov[d], mov[d]);
            chk("m_unf", d, d_un[d], mun[d]);
            chk("m_dv", d, d_dv[d], edv);
            chk("m_out", d, d_out[d], eo);
        end
    end

    task automatic step(input logic w, input logic r,
                        input logic [7:0] v,
                        input logic f, input logic c);
        we    = w;
        re    = r;
        din   = v;
        flush = f;
        cf    = c;
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [7:0] exp_v;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("rst_empty", d, d_em[d], 1'b1);
            chk("rst_count", d, d_cnt[d], 0);
            chk("rst_out", d, d_out[d], 8'h00);
        end

        // Fill 1..5 and drain: registered output, one cycle late.
        for (int i = 1; i <= 5; i++) step(1, 0, 8'(i), 0, 0);
        chk("full5", 0, d_fu[0], 1'b1);
        chk("cnt5", 0, d_cnt[0], 5);
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("seq_out", 0, d_out[0], i);
            chk("seq_dv", 0, d_dv[0], 1'b1);
        end
        chk("empty5", 0, d_em[0], 1'b1);
        step(0, 0, 8'h00, 0, 0);
        chk("dv_pulse", 0, d_dv[0], 1'b0);

        // Pointer wrap on depth 5.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 4; k++)
                step(1, 0, 8'(10 + 4 * r + k), 0, 0);
            chk("wrap_cnt", 0, d_cnt[0], 4);
            for (int k = 0; k < 4; k++) begin
                step(0, 1, 8'h00, 0, 0);
                chk("wrap_out", 0, d_out[0], 10 + 4 * r + k);
            end
        end

        // Overflow on full depth-8, then drain and underflow.
        for (int i = 0; i < 8; i++) step(1, 0, 8'(8'h30 + i), 0, 0);
        chk("fill8", 1, d_cnt[1], 8);
        step(1, 0, 8'hAA, 0, 0);
        chk("ovf_cnt", 1, d_cnt[1], 8);
        chk("ovf_set", 1, d_ov[1], 1'b1);
        step(0, 0, 8'h00, 0, 0);
        step(0, 0, 8'h00, 0, 0);
        chk("ovf_hold", 1, d_ov[1], 1'b1);
        step(0, 0, 8'h00, 0, 1);
        chk("ovf_clr", 1, d_ov[1], 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'h00, 0, 0);
            chk("drain8", 1, d_out[1], 8'h30 + i);
        end
        step(0, 1, 8'h00, 0, 0);
        chk("unf_set", 1, d_un[1], 1'b1);
        step(0, 1, 8'h00, 0, 1);
        chk("set_wins", 1, d_un[1], 1'b1);
        step(0, 0, 8'h00, 0, 1);
        chk("unf_clr", 1, d_un[1], 1'b0);

        // Simultaneous read+write at count 3, then at full.
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h40 + i), 0, 0);
        for (int k = 0; k < 4; k++) begin
            step(1, 1, 8'(8'h50 + k), 0, 0);
            exp_v = (k < 3) ? 8'(8'h40 + k) : 8'h50;
            chk("rw_cnt", 1, d_cnt[1], 3);
            chk("rw_out", 1, d_out[1], exp_v);
        end
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h60 + i), 0, 0);
        chk("rw_full", 1, d_fu[1], 1'b1);
        step(1, 1, 8'hBB, 0, 0);
        chk("rwf_cnt", 1, d_cnt[1], 7);
        chk("rwf_ovf", 1, d_ov[1], 1'b1);
        chk("rwf_out", 1, d_out[1], 8'h51);

        // Show-ahead: word visible without a read.
        step(0, 0, 8'h00, 1, 0);
        step(1, 0, 8'h11, 0, 0);
        chk("sa_out", 2, d_out[2], 8'h11);
        chk("sa_dv", 2, d_dv[2], 1'b1);
        step(0, 1, 8'h00, 0, 0);
        chk("sa_empty", 2, d_em[2], 1'b1);
        chk("sa_dv0", 2, d_dv[2], 1'b0);

        // Async reset mid-fill at count 4, seen before any edge.
        for (int i = 0; i < 4; i++) step(1, 0, 8'(8'h80 + i), 0, 0);
        chk("pre_rst", 1, d_cnt[1], 4);
        reset = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            chk("arst_cnt", d, d_cnt[d], 0);
            chk("arst_empty", d, d_em[d], 1'b1);
            chk("arst_full", d, d_fu[d], 1'b0);
            chk("arst_ae", d, d_ae[d], 1'b1);
            chk("arst_af", d, d_af[d], 1'b0);
            chk("arst_ovf", d, d_ov[d], 1'b0);
            chk("arst_unf", d, d_un[d], 1'b0);
            chk("arst_dv", d, d_dv[d], 1'b0);
            chk("arst_out", d, d_out[d], 8'h00);
        end
        @(posedge clock);
        #1 reset = 1'b0;

        // Threshold edges: AE_LEVEL=2, AF_LEVEL=6.
        for (int i = 1; i <= 8; i++) begin
            step(1, 0, 8'(8'h90 + i), 0, 0);
            chk("thr_ae", 1, d_ae[1], i <= 2);
            chk("thr_af", 1, d_af[1], i >= 6);
        end

        // Flush at count 5 keeps sticky flags; wins over rd/wr.
        step(0, 0, 8'h00, 1, 0);
        step(0, 1, 8'h00, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'hC0 + i), 0, 0);
        chk("pre_flush", 1, d_cnt[1], 5);
        step(1, 1, 8'h77, 1, 0);
        chk("flush_cnt", 1, d_cnt[1], 0);
        chk("flush_unf", 1, d_un[1], 1'b1);
        chk("flush_dv", 1, d_dv[1], 1'b0);
        step(1, 0, 8'h78, 0, 0);
        chk("post_flush", 2, d_out[2], 8'h78);
        step(0, 0, 8'h00, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/fifo_buffer_param.md
Name: fifo_buffer_param

Overview:
Single-clock synchronous FIFO. Parametrised successor to the team's fixed 8x8 FIFO, generalised in width and depth (depth need not be a power of two). Adds:
- selectable output mode: registered or show-ahead
- programmable almost-full/almost-empty thresholds
- sticky overflow/underflow error flags
- synchronous flush

Sits between producer/consumer datapaths in the same clock domain.

Parameters:
WIDTH, 8, data width in bits (>=1)
DEPTH, 8, number of entries (>=2, any integer)
SHOW_AHEAD, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through
AF_LEVEL, DEPTH-1, almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 1, almost_empty asserts when count <= AE_LEVEL

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high reset
flush  in  1  synchronous clear of FIFO contents
read_enable  in  1  read request
write_enable  in  1  write request
clear_flags  in  1  synchronous clear of sticky error flags
fifo_in  in  WIDTH  write data
fifo_out  out  WIDTH  read data
data_valid  out  1  fifo_out holds valid read data (meaning per mode)
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_empty  out  1  count <= AE_LEVEL
almost_full  out  1  count >= AF_LEVEL
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
fifo_counter  out  CNT_W  occupancy, CNT_W = clog2(DEPTH+1)

Behaviour:
- Pointers: PTR_W = max(1, clog2(DEPTH)). Each pointer wraps from DEPTH-1 to 0 explicitly; never relies on natural binary overflow.
- Accept rules:
  - wr_acc = write_enable & !full
  - rd_acc = read_enable & !empty
  - Both evaluate against the pre-edge count.
- Simultaneous accepted read and write: both pointers advance; count unchanged.
- Write while full: data dropped, write_ptr and count unchanged, overflow set.
- Read while empty: no pointer/count change, underflow set, fifo_out unchanged.
- Counter: +1 on wr_acc only, -1 on rd_acc only, hold otherwise. Never exceeds DEPTH; never underflows.
- empty, full, almost_empty and almost_full are combinational decodes of fifo_counter.
- SHOW_AHEAD=0:
  - On rd_acc, fifo_out <= mem[read_ptr] at that edge; otherwise fifo_out holds.
  - data_valid is a registered 1-cycle pulse following each rd_acc.
- SHOW_AHEAD=1:
  - fifo_out = mem[read_ptr], continuously driven.
  - data_valid = !empty.
  - Asserting read_enable consumes the displayed word; the next word appears after that edge.
  - A word written into an empty FIFO is visible the cycle after the write edge.
- Sticky flags: overflow/underflow set on the offending edge and hold until clear_flags or reset. If set and clear occur in the same cycle, set wins.
- flush (synchronous):
  - read_ptr, write_ptr and fifo_counter go to 0.
  - data_valid goes to 0.
  - Registered fifo_out goes to 0.
  - Sticky flags are unaffected.
  - flush takes priority over same-cycle read/write; neither is accepted and neither sets an error flag.
- reset (asynchronous, active-high): immediately forces the following, mid-operation or not:
  - pointers, fifo_counter, fifo_out, data_valid, overflow and underflow all to 0
  - empty=1, full=0, almost_empty=1 (AE_LEVEL>=0), almost_full=0
- Storage array is not reset; contents are undefined after reset/flush and never observable.

Test Plan:
- DEPTH=5, SHOW_AHEAD=0: write 1..5, then read 5 times -> fifo_out 1,2,3,4,5 each one cycle after its read; full=1 after 5th write; empty=1 after 5th read; data_valid pulses 5 times.
- DEPTH=5: 3 rounds of 4 writes/4 reads (pointer wrap past index 4) -> data order preserved (values 10..21); fifo_counter never >4.
- Full FIFO (DEPTH=8), write_enable with fifo_in=0xAA -> counter stays 8, overflow=1 until clear_flags pulse, 0xAA never read. Read on empty -> underflow=1.
- Count=3, simultaneous read+write for 4 cycles -> fifo_counter stays 3, output order intact. At full, simultaneous read+write -> read accepted, write dropped, overflow=1, count=7.
- SHOW_AHEAD=1: write 0x11 into empty FIFO -> next cycle fifo_out=0x11, data_valid=1 with no read issued; read -> empty=1, data_valid=0.
- AF_LEVEL=6, AE_LEVEL=2: fill 0->8 -> almost_empty drops at count 3, almost_full rises at 6. Assert reset mid-fill at count 4 -> all outputs at reset values in the same cycle. flush at count 5 -> counter 0 next edge, sticky flags retained.
